if_fetch: RTL and testbench

Instruction-fetch stage of the MIPS pipeline: owns the PC, issues requests to instruction memory over a req/ack handshake, and presents each fetched instruction with its PC+4 to the IF/ID pipeline register. Drives the IF/ID register's load (`valid_out`) and clear (`flush_out`) inputs, and honours stalls from the hazard unit and redirects (branch/jump) from the ID stage. It has a one-entry skid buffer, so a memory return that arrives during a stall is never lost.

---
 rtl/if_fetch_pkg.sv | 26 ++
 rtl/fetch_skid_buf.sv | 47 ++++
 rtl/if_fetch.sv | 206 ++++++++++++++++++++
 tb/tb_if_fetch.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_pkg
// Shared definitions for the MIPS instruction-fetch stage: default reset PC,
// NOP encoding, fetch FSM state type, skid-buffer entry width and the PC
// increment helper.
// ---------------------------------------------------------------------------
package if_fetch_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

   // One buffered fetch result: {instruction, fetch address + 4}
   localparam int ENTRY_W = 64;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_t;

   // Sequential fetch address; wraps modulo 2^32
   function automatic logic [31:0] next_word(input logic [31:0] addr);
      return addr + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// ---------------------------------------------------------------------------
// fetch_skid_buf
// One-entry holding register for a fetch result that returns while the IF/ID
// output register is stalled.
// Ports:
//   clk, reset     clock, synchronous active-low reset
//   load           capture data_in (wins over unload: refill in same cycle)
//   unload         entry consumed by the output register
//   clear          drop the entry (redirect); highest priority after reset
//   data_in        {instr, pc4} to capture
//   data_out       stored {instr, pc4}
//   full           entry present
// ---------------------------------------------------------------------------
module fetch_skid_buf
   import if_fetch_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               unload,
   input  logic               clear,
   input  logic [ENTRY_W-1:0] data_in,
   output logic [ENTRY_W-1:0] data_out,
   output logic               full
);

   logic [ENTRY_W-1:0] data_reg;
   logic               full_reg;

   always_ff @(posedge clk) begin
      if (!reset) begin
         data_reg <= '0;
         full_reg <= 1'b0;
      end else if (clear) begin
         full_reg <= 1'b0;
      end else if (load) begin
         data_reg <= data_in;
         full_reg <= 1'b1;
      end else if (unload) begin
         full_reg <= 1'b0;
      end
   end

   assign data_out = data_reg;
   assign full     = full_reg;

endmodule

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch
// Instruction-fetch stage: owns the PC, requests instructions over a req/ack
// handshake and presents {instr, pc+4} to the IF/ID register. Stalls hold the
// output register; one return arriving during a stall lands in a skid buffer.
// Branch/jump redirects flush IF/ID and squash any in-flight fetch.
// Ports:
//   clk, reset                     clock, synchronous active-low reset
//   stall                          IF/ID does not load this cycle
//   branch_taken, branch_target    branch redirect pulse and address
//   jump, jump_target              jump redirect pulse and address (priority)
//   imem_req, imem_addr            registered request / address to memory
//   imem_ack, imem_rdata           completion and instruction word
//   instr_out, pc4_out             fetched instruction and its address + 4
//   valid_out                      output register holds a valid instruction
//   flush_out                      one-cycle IF/ID clear after a redirect
// ---------------------------------------------------------------------------
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_out,
   output logic [31:0] pc4_out,
   output logic        valid_out,
   output logic        flush_out
);

   fetch_state_t state_reg, state_next;
   logic [31:0]  pc_reg, pc_next;
   logic         req_reg, req_next;
   logic [31:0]  addr_reg, addr_next;
   logic [31:0]  instr_reg, instr_next;
   logic [31:0]  pc4_reg, pc4_next;
   logic         valid_reg, valid_next;
   logic         flush_reg, flush_next;

   logic               redirect;
   logic [31:0]        redirect_target;
   logic               transfer;
   logic               out_free;
   logic               ack_live;
   logic               fetch_ack;
   logic [31:0]        ack_pc4;
   logic               skid_load, skid_unload, skid_clear;
   logic               skid_full, skid_empty_next;
   logic [ENTRY_W-1:0] skid_data;

   fetch_skid_buf u_skid (
      .clk      (clk),
      .reset    (reset),
      .load     (skid_load),
      .unload   (skid_unload),
      .clear    (skid_clear),
      .data_in  ({imem_rdata, ack_pc4}),
      .data_out (skid_data),
      .full     (skid_full)
   );

   assign redirect        = jump | branch_taken;
   assign redirect_target = jump ? jump_target : branch_target;
   assign transfer        = valid_reg & ~stall;
   assign out_free        = ~valid_reg | transfer;
   // An ack only counts while a request is outstanding; stray acks in IDLE
   // (e.g. from a transaction abandoned by reset) are ignored.
   assign ack_live        = imem_ack & req_reg & (state_reg != IDLE);
   assign fetch_ack       = ack_live & (state_reg == WAIT);
   assign ack_pc4         = next_word(addr_reg);

   // Output register and skid buffer steering
   always_comb begin
      instr_next  = instr_reg;
      pc4_next    = pc4_reg;
      valid_next  = valid_reg;
      skid_load   = 1'b0;
      skid_unload = 1'b0;
      skid_clear  = 1'b0;

      if (redirect) begin
         valid_next = 1'b0;
         skid_clear = 1'b1;
      end else if (out_free) begin
         if (skid_full) begin
            // Buffered entry is older than any return this cycle
            {instr_next, pc4_next} = skid_data;
            valid_next  = 1'b1;
            skid_unload = 1'b1;
            skid_load   = fetch_ack;
         end else if (fetch_ack) begin
            instr_next = imem_rdata;
            pc4_next   = ack_pc4;
            valid_next = 1'b1;
         end else begin
            valid_next = 1'b0;
         end
      end else begin
         skid_load = fetch_ack;
      end
   end

   assign skid_empty_next = skid_clear | (~skid_load & (~skid_full | skid_unload));

   // Fetch FSM: PC and request generation
   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      req_next   = req_reg;
      addr_next  = addr_reg;
      flush_next = redirect;

      case (state_reg)
         IDLE: begin
            if (redirect) begin
               pc_next = redirect_target;
            end else if (!skid_full) begin
               req_next   = 1'b1;
               addr_next  = pc_reg;
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (ack_live) begin
               if (redirect) begin
                  pc_next    = redirect_target;
                  req_next   = 1'b0;
                  state_next = IDLE;
               end else begin
                  pc_next = ack_pc4;
                  if (skid_empty_next) begin
                     // Back-to-back request keeps one instruction per cycle
                     req_next  = 1'b1;
                     addr_next = ack_pc4;
                  end else begin
                     req_next   = 1'b0;
                     state_next = IDLE;
                  end
               end
            end else if (redirect) begin
               // Address must stay put until the outstanding ack arrives
               pc_next    = redirect_target;
               state_next = DISCARD;
            end
         end
         DISCARD: begin
            if (ack_live) begin
               if (redirect) begin
                  pc_next    = redirect_target;
                  req_next   = 1'b0;
                  state_next = IDLE;
               end else begin
                  req_next   = 1'b1;
                  addr_next  = pc_reg;
                  state_next = WAIT;
               end
            end else if (redirect) begin
               pc_next = redirect_target;
            end
         end
         default: begin
            req_next   = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg <= IDLE;
         pc_reg    <= RESET_PC;
         req_reg   <= 1'b0;
         addr_reg  <= RESET_PC;
         instr_reg <= NOP_INSTR;
         pc4_reg   <= 32'h0;
         valid_reg <= 1'b0;
         flush_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         req_reg   <= req_next;
         addr_reg  <= addr_next;
         instr_reg <= instr_next;
         pc4_reg   <= pc4_next;
         valid_reg <= valid_next;
         flush_reg <= flush_next;
      end
   end

   assign imem_req  = req_reg;
   assign imem_addr = addr_reg;
   assign instr_out = instr_reg;
   assign pc4_out   = pc4_reg;
   assign valid_out = valid_reg;
   assign flush_out = flush_reg;

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch
// Directed bench for if_fetch. A program-order model (expected next PC of
// the instruction stream, redirected on jump/branch) checks every cycle the
// output is valid; handshake rules are checked every cycle; directed phases
// pin the model with literal addresses and counts.
// ---------------------------------------------------------------------------
module tb_if_fetch;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        reset, stall, branch_taken, jump;
   logic [31:0] branch_target, jump_target;
   logic        imem_req, imem_ack, valid_out, flush_out;
   logic [31:0] imem_addr, imem_rdata, instr_out, pc4_out;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   if_fetch #(.RESET_PC(RST_PC)) dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .instr_out     (instr_out),
      .pc4_out       (pc4_out),
      .valid_out     (valid_out),
      .flush_out     (flush_out)
   );

   // Instruction memory contents: distinct word per address
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // ---------------- model / compare process ----------------
   logic [31:0] exp_pc;
   logic        prev_req = 1'b0, prev_ack = 1'b0, prev_redirect = 1'b0;
   logic [31:0] prev_addr = 32'h0;
   logic        rst_q;
   int          xfer_cnt  = 0;
   int          flush_cnt = 0;
   logic [31:0] req_log[$];
   logic [31:0] xfer_log[$];

   always @(posedge clk) rst_q <= reset;

   always @(negedge clk) begin
      if (rst_q === 1'b0) begin
         chk("rst_req",   32'(imem_req),  32'h0);
         chk("rst_valid", 32'(valid_out), 32'h0);
         chk("rst_flush", 32'(flush_out), 32'h0);
         chk("rst_instr", instr_out, 32'h0);
         chk("rst_pc4",   pc4_out,   32'h0);
         chk("rst_addr",  imem_addr, RST_PC);
      end
      if (reset !== 1'b1) begin
         exp_pc        = RST_PC;
         prev_req      = 1'b0;
         prev_ack      = 1'b0;
         prev_redirect = 1'b0;
      end else begin
         if (rst_q === 1'b1 && prev_req && !prev_ack) begin
            chk("req_hold",  32'(imem_req), 32'h1);
            chk("addr_hold", imem_addr, prev_addr);
         end
         chk("flush_pulse", 32'(flush_out), 32'(prev_redirect));
         if (flush_out) flush_cnt++;
         if (prev_redirect) chk("valid_after_redirect", 32'(valid_out), 32'h0);
         if (imem_req && imem_ack) req_log.push_back(imem_addr);
         if (valid_out) begin
            chk("instr", instr_out, mem_word(exp_pc));
            chk("pc4",   pc4_out,   exp_pc + 32'd4);
            if (!stall) begin
               xfer_log.push_back(pc4_out);
               xfer_cnt++;
               exp_pc = exp_pc + 32'd4;
            end
         end
         if (jump)              exp_pc = jump_target;
         else if (branch_taken) exp_pc = branch_target;
         prev_req      = imem_req;
         prev_ack      = imem_ack;
         prev_addr     = imem_addr;
         prev_redirect = jump | branch_taken;
      end
   end

   // ---------------- memory responder + stimulus ----------------
   int          mem_wait  = 0;
   int          slow_wait = 0;
   int          mem_cnt   = 0;
   logic [31:0] slow_addr = 32'h1;
   logic        mem_force = 1'b0;

   task automatic tick();
      int w;
      @(posedge clk); #1;
      w = (imem_addr == slow_addr) ? slow_wait : mem_wait;
      if (mem_force) begin
         imem_ack   = 1'b1;
         imem_rdata = 32'hBAD0_BAD0;
         mem_force  = 1'b0;
         mem_cnt    = 0;
      end else if (reset && imem_req) begin
         if (mem_cnt >= w) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
            mem_cnt    = 0;
         end else begin
            imem_ack   = 1'b0;
            imem_rdata = 32'h0;
            mem_cnt++;
         end
      end else begin
         imem_ack   = 1'b0;
         imem_rdata = 32'h0;
         mem_cnt    = 0;
      end
   endtask

   task automatic settle();
      @(negedge clk); #1;
   endtask

   function automatic logic [31:0] rlog(input int i);
      return (i < req_log.size()) ? req_log[i] : 32'hDEAD_DEAD;
   endfunction

   function automatic logic [31:0] xlog(input int i);
      return (i < xfer_log.size()) ? xfer_log[i] : 32'hDEAD_DEAD;
   endfunction

   initial begin
      int base;
      int hits;
      bit found;
      reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
      branch_target = 32'h0; jump_target = 32'h0;
      imem_ack = 1'b0; imem_rdata = 32'h0;

      // Phase 0/1: reset, then free-running zero-wait fetch
      repeat (3) tick();
      settle();
      chk("p0_addr",  imem_addr, 32'h100);
      chk("p0_valid", 32'(valid_out), 32'h0);
      tick();
      reset = 1'b1;
      req_log.delete(); xfer_log.delete(); xfer_cnt = 0;
      repeat (8) tick();
      settle();
      chk("p1_req0", rlog(0), 32'h100);
      chk("p1_req1", rlog(1), 32'h104);
      chk("p1_req2", rlog(2), 32'h108);
      chk("p1_pc4_0", xlog(0), 32'h104);
      chk("p1_pc4_1", xlog(1), 32'h108);
      chk("p1_pc4_2", xlog(2), 32'h10C);
      chk("p1_xfers", xfer_cnt, 7);
      $display("[TB] phase1 reset/stream: %0d transfers", xfer_cnt);

      // Phase 2: three-cycle stall with memory still acking
      tick(); stall = 1'b1;
      tick();
      tick();
      settle();
      chk("p2_req_drop", 32'(imem_req), 32'h0);
      chk("p2_valid_hold", 32'(valid_out), 32'h1);
      tick(); stall = 1'b0;
      base = xfer_cnt;
      repeat (9) tick();
      settle();
      chk("p2_progress", 32'(xfer_cnt - base >= 9), 32'h1);
      $display("[TB] phase2 stall: %0d transfers after release", xfer_cnt - base);

      // Phase 3: branch while fetch of 0x10C is waiting
      slow_addr = 32'h10C; slow_wait = 4;
      tick(); jump = 1'b1; jump_target = 32'h100;
      tick(); jump = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (imem_req && imem_addr == 32'h10C) begin
            found = 1'b1;
            break;
         end
      end
      chk("p3_reach_10c", 32'(found), 32'h1);
      tick();
      branch_taken = 1'b1; branch_target = 32'h200; flush_cnt = 0;
      tick();
      branch_taken = 1'b0;
      req_log.delete(); xfer_log.delete();
      repeat (10) tick();
      settle();
      chk("p3_ack_discard", rlog(0), 32'h10C);
      chk("p3_req_target",  rlog(1), 32'h200);
      chk("p3_first_pc4",   xlog(0), 32'h204);
      chk("p3_flush_cnt",   flush_cnt, 1);
      hits = 0;
      foreach (xfer_log[i]) if (xfer_log[i] == 32'h110) hits++;
      chk("p3_no_10c_data", hits, 0);
      $display("[TB] phase3 branch: first pc4 %h", xlog(0));

      // Phase 4: jump and branch together, with stall
      slow_addr = 32'h1;
      tick();
      stall = 1'b1; jump = 1'b1; jump_target = 32'h300;
      branch_taken = 1'b1; branch_target = 32'h200; flush_cnt = 0;
      tick();
      stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
      xfer_log.delete();
      repeat (10) tick();
      settle();
      chk("p4_first_pc4", xlog(0), 32'h304);
      chk("p4_flush_cnt", flush_cnt, 1);
      $display("[TB] phase4 jump priority: first pc4 %h", xlog(0));

      // Phase 5: PC wrap at top of address space
      tick(); jump = 1'b1; jump_target = 32'hFFFF_FFFC;
      tick(); jump = 1'b0;
      req_log.delete(); xfer_log.delete();
      repeat (8) tick();
      settle();
      chk("p5_req_top",  rlog(0), 32'hFFFF_FFFC);
      chk("p5_req_wrap", rlog(1), 32'h0);
      chk("p5_pc4_wrap", xlog(0), 32'h0);
      chk("p5_pc4_next", xlog(1), 32'h4);
      $display("[TB] phase5 wrap: pc4 %h then %h", xlog(0), xlog(1));

      // Phase 6: reset during WAIT, stale ack afterwards
      mem_wait = 5;
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (imem_req && !imem_ack) begin
            found = 1'b1;
            break;
         end
      end
      chk("p6_pending", 32'(found), 32'h1);
      reset = 1'b0;
      mem_force = 1'b1;
      tick();
      reset = 1'b1;
      settle();
      chk("p6_req",   32'(imem_req),  32'h0);
      chk("p6_valid", 32'(valid_out), 32'h0);
      chk("p6_instr", instr_out, 32'h0);
      chk("p6_pc4",   pc4_out,   32'h0);
      mem_wait = 0;
      xfer_log.delete();
      tick();
      settle();
      chk("p6_valid_after_ack", 32'(valid_out), 32'h0);
      chk("p6_restart_addr", imem_addr, RST_PC);
      repeat (6) tick();
      settle();
      chk("p6_first_pc4", xlog(0), 32'h104);
      $display("[TB] phase6 reset mid-fetch: first pc4 %h", xlog(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
